// File: rtl/lockin_pkg.sv
// Shared types and default widths for the lock-in chopper/integrator path.
package lockin_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int DEF_DATA_W = 14;
  localparam int DEF_HALF_W = 16;
  localparam int DEF_NCYC_W = 8;
  localparam int DEF_ACC_W  = 32;

  // Shortest half-period that still leaves a distinct first and last cycle.
  localparam int MIN_HALF   = 2;

endpackage

// File: rtl/chopper_sequencer_phase_gen.sv
// Chopper timebase: phase counter within a half, period counter, chopper toggle.
// All outputs derive from registered state so they move together with busy.
module chopper_phase_gen
  import lockin_pkg::*;
#(
  parameter int HALF_W = DEF_HALF_W,
  parameter int NCYC_W = DEF_NCYC_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              running_i,
  input  logic              run_next_i,
  input  logic [HALF_W-1:0] half_i,
  input  logic [HALF_W-1:0] blank_i,
  input  logic [NCYC_W-1:0] ncyc_i,
  output logic              chopper_o,
  output logic              gate_o,
  output logic              last_cycle_o,
  output logic              period_end_o
);

  logic [HALF_W-1:0] ph_q, ph_d;
  logic [NCYC_W-1:0] per_q, per_d;
  logic              chop_q, chop_d;
  logic              half_end;
  logic              final_period;

  assign half_end     = running_i && (ph_q == (half_i - HALF_W'(1)));
  // Level: currently in the low half of the last period of the integration.
  assign final_period = running_i && !chop_q && (per_q == (ncyc_i - NCYC_W'(1)));

  always_comb begin
    ph_d   = ph_q;
    per_d  = per_q;
    chop_d = chop_q;
    if (!run_next_i) begin
      ph_d   = '0;
      per_d  = '0;
      chop_d = 1'b0;
    end else if (!running_i) begin
      ph_d   = '0;
      per_d  = '0;
      chop_d = 1'b1;
    end else if (half_end) begin
      ph_d   = '0;
      chop_d = ~chop_q;
      if (!chop_q) begin
        per_d = final_period ? '0 : per_q + NCYC_W'(1);
      end
    end else begin
      ph_d = ph_q + HALF_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ph_q   <= '0;
      per_q  <= '0;
      chop_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      per_q  <= per_d;
      chop_q <= chop_d;
    end
  end

  assign chopper_o    = chop_q;
  assign gate_o       = running_i && (ph_q >= blank_i);
  assign last_cycle_o = half_end;
  assign period_end_o = final_period;

endmodule

// File: rtl/chopper_sequencer.sv
// Lock-in chopper sequencer: config latch, run FSM, signed integrator, result register.
//   state   | meaning
//   ST_IDLE | chopper parked low, waiting for enable_in; config latched on exit
//   ST_RUN  | chopper running, gated samples integrated over N periods
module chopper_sequencer
  import lockin_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int HALF_W = DEF_HALF_W,
  parameter int NCYC_W = DEF_NCYC_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     enable_in,
  input  logic [HALF_W-1:0]        half_period_in,
  input  logic [HALF_W-1:0]        blank_in,
  input  logic [NCYC_W-1:0]        ncycles_in,
  input  logic signed [DATA_W-1:0] in_sig,
  output logic                     chopper_sig,
  output logic                     gate_out,
  output logic signed [ACC_W-1:0]  out_sig,
  output logic                     out_valid,
  output logic                     busy
);

  state_e                   state_q, state_d;
  logic [HALF_W-1:0]        half_q, half_d;
  logic [HALF_W-1:0]        blank_q, blank_d;
  logic [NCYC_W-1:0]        ncyc_q, ncyc_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  out_q, out_d;
  logic                     valid_q, valid_d;

  logic                     running;
  logic                     chop;
  logic                     gate;
  logic                     last_cycle;
  logic                     period_end;
  logic signed [ACC_W-1:0]  samp;
  logic signed [ACC_W-1:0]  acc_sum;

  assign running = (state_q == ST_RUN);
  assign samp    = {{(ACC_W-DATA_W){in_sig[DATA_W-1]}}, in_sig};
  assign acc_sum = chop ? (acc_q + samp) : (acc_q - samp);

  chopper_phase_gen #(
    .HALF_W (HALF_W),
    .NCYC_W (NCYC_W)
  ) u_phase (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .running_i    (running),
    .run_next_i   (state_d == ST_RUN),
    .half_i       (half_q),
    .blank_i      (blank_q),
    .ncyc_i       (ncyc_q),
    .chopper_o    (chop),
    .gate_o       (gate),
    .last_cycle_o (last_cycle),
    .period_end_o (period_end)
  );

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    blank_d = blank_q;
    ncyc_d  = ncyc_q;
    acc_d   = acc_q;
    out_d   = out_q;
    valid_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (enable_in) begin
        state_d = ST_RUN;
        half_d  = (half_period_in < HALF_W'(MIN_HALF)) ? HALF_W'(MIN_HALF) : half_period_in;
        blank_d = blank_in;
        ncyc_d  = (ncycles_in == '0) ? NCYC_W'(1) : ncycles_in;
        acc_d   = '0;
      end
    end else begin
      if (gate) begin
        acc_d = acc_sum;
      end
      // Commit includes this cycle's sample; the result survives an enable drop here.
      if (last_cycle && period_end) begin
        out_d   = acc_d;
        valid_d = 1'b1;
        acc_d   = '0;
      end
      if (!enable_in) begin
        state_d = ST_IDLE;
        acc_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      half_q  <= HALF_W'(MIN_HALF);
      blank_q <= '0;
      ncyc_q  <= NCYC_W'(1);
      acc_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      blank_q <= blank_d;
      ncyc_q  <= ncyc_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign chopper_sig = chop;
  assign gate_out    = gate;
  assign busy        = running;
  assign out_sig     = out_q;
  assign out_valid   = valid_q;

endmodule

// File: doc/chopper_sequencer.md
# chopper_sequencer

Controller for the lock-in synchronous demodulation path. It generates the chopper reference from `clk_in`, with a programmable half-period. After each chopper edge it blanks a programmable number of settling cycles. Over N whole chopper periods it accumulates the input with a sign given by chopper phase (+ while high, − while low), then presents the integrated result with a one-cycle valid strobe. It replaces free-running chopper generation plus external integration, so the chopper edges and the integration window are locked to one counter.

## Interface
- `DATA_W`, 14, input sample width (signed two's complement)
- `HALF_W`, 16, half-period / blanking counter width
- `NCYC_W`, 8, periods-per-integration count width
- `ACC_W`, 32, accumulator and result width
- `clk_in`  in  1  system clock; all logic on rising edge
- `rst_in`  in  1  synchronous, active-high reset
- `enable_in`  in  1  run request; level-sensitive
- `half_period_in`  in  HALF_W  cycles per chopper half-phase
- `blank_in`  in  HALF_W  cycles ignored after each chopper edge
- `ncycles_in`  in  NCYC_W  full chopper periods per integration
- `in_sig`  in  DATA_W  signed signal sample
- `chopper_sig`  out  1  chopper reference (high half first)
- `gate_out`  out  1  high when the current `in_sig` is being accumulated
- `out_sig`  out  ACC_W  signed integration result, held until next result
- `out_valid`  out  1  one-cycle strobe, new `out_sig`
- `busy`  out  1  high in RUN

## Operation
- States: IDLE, RUN.
- Reset sets the state to IDLE. It also sets `chopper_sig`, `gate_out`, `out_valid`, `busy` and `out_sig` to 0, and clears the accumulator and all counters.
- **IDLE**
  - `chopper_sig` = 0, `gate_out` = 0.
  - When `enable_in` = 1, latch the config and go to RUN.
  - Config sanitisation at latch:
    - half-period < 2 is forced to 2.
    - ncycles = 0 is forced to 1.
    - blank ≥ half-period gives `gate_out` always 0. The block still runs and reports 0.
- **RUN**
  - A phase counter `ph` counts 0..H−1 within each half. Each half therefore lasts exactly H cycles.
  - `chopper_sig` toggles at the end of each half.
  - A period counter counts completed low halves.
  - `gate_out` = (`ph` ≥ blank).
  - When gated: acc += sext(`in_sig`) if `chopper_sig` = 1, else acc −= sext(`in_sig`).
  - Accumulation wraps modulo 2^ACC_W with no saturation. The integrator sizes ACC_W ≥ DATA_W + 1 + log2(2·N·H).
- **End of integration:** in the last cycle of the N-th low half:
  - `out_sig` ← acc including that cycle's sample.
  - `out_valid` pulses 1 on the next cycle.
  - acc clears.
  - The next integration starts immediately, with `chopper_sig` high and `ph` = 0. No gap cycles.
- **Config changes in RUN** are ignored. They take effect only on the next IDLE→RUN transition.
- **`enable_in` low in RUN:** on the next cycle the block goes to IDLE and forces `chopper_sig`/`gate_out` to 0. The partial acc is discarded and no strobe is produced. `out_sig` keeps its last value.
- **`enable_in` falls in the final cycle of an integration:** that result is still committed and strobed.
- **`rst_in` mid-RUN:** same as reset; any pending strobe is cancelled.

## Timing
- `enable_in` = 1 is sampled in IDLE at cycle T. RUN starts at T+1: `busy` = 1, `chopper_sig` = 1, `ph` = 0.
- `chopper_sig`, `gate_out` and `busy` are registered and change together. `in_sig` is sampled in any cycle where `gate_out` = 1.
- The first `out_valid` occurs at T+1+2·N·H. Subsequent strobes follow every 2·N·H cycles.
- `out_sig` updates in the same cycle `out_valid` is high.
- Latency from the last accumulated sample to the strobe is 1 cycle.

## Structure
- Shared package `lockin_pkg` holds:
  - the state enum (IDLE, RUN)
  - default widths (DATA_W, HALF_W, NCYC_W, ACC_W)
  - the minimum half-period constant (2)
- Sub-module `chopper_phase_gen` holds the phase counter, period counter and chopper toggle. It outputs `chopper_sig`, `gate`, `last_cycle` and `period_end`.
- The top level holds the FSM, config latch, signed accumulator and output registers.

## Test plan
- H=4, blank=1, N=1, `in_sig`=+100 constant, enable at cycle 0 -> `chopper_sig` high cycles 1–4 and low 5–8; `gate_out` low at cycles 1 and 5; `out_valid` at cycle 9 with `out_sig`=0.
- Same config, `in_sig`=+100 while `chopper_sig`=1 and −100 while 0 -> `out_sig`=600 at cycle 9 and again at cycle 17.
- H=3, blank=0, N=2, `in_sig`=−5 while high and +7 while low -> `out_sig` = 2·(−15 − 21) = −72; strobe every 12 cycles.
- half_period_in=0, ncycles_in=0, blank=0, `in_sig`=1 while high -> treated as H=2, N=1; `out_sig`=2; strobe every 4 cycles.
- blank_in=8, H=4 -> `gate_out` never high; `out_sig`=0 strobed every 8 cycles.
- Drop `enable_in` mid-integration, then reassert with H changed from 4 to 6 -> no strobe for the partial run; `out_sig` unchanged; new run uses H=6. Separately, assert `rst_in` mid-RUN -> all outputs 0 on the next cycle.
